// File: rtl/stack_sequencer_pkg.sv
// Shared types for the stack sequencer: opcodes, FSM states, default sizing.
package stack_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_PUSHI = 3'd0,
    OP_POP   = 3'd1,
    OP_TOS   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_AND   = 3'd5,
    OP_NOT   = 3'd6,
    OP_DUP   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4
  } state_e;

  function automatic logic is_binary(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [1:0] operands(op_e op);
    if (op == OP_PUSHI) return 2'd0;
    if (is_binary(op))  return 2'd2;
    return 2'd1;
  endfunction

endpackage

// File: rtl/stack_sequencer_alu.sv
// Combinational result unit; a is the top-of-stack operand, b the one below it.
module stack_sequencer_alu
  import stack_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op_e'(opcode))
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_NOT:  result = ~a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Command sequencer driving an external registered stack.
// Define STACK_SEQUENCER_GUARD_EN to reject under/overflowing commands and flag err.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op_code,
  input  logic [WIDTH-1:0]         op_imm,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic                     stk_tos,
  output logic [WIDTH-1:0]         stk_wdata,
  input  logic [WIDTH-1:0]         stk_rdata,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int DW = $clog2(DEPTH) + 1;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, w_q, res_q;
  logic [WIDTH-1:0] alu_a, alu_y, res_now;
  logic [DW-1:0]    depth_q;
  logic             accept, reject;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign depth    = depth_q;

`ifdef STACK_SEQUENCER_GUARD_EN
  logic err_q;

  always_comb begin
    reject = 1'b0;
    if (accept) begin
      reject = (int'(depth_q) < int'(operands(op_e'(op_code)))) ||
               (((op_e'(op_code) == OP_PUSHI) || (op_e'(op_code) == OP_DUP)) &&
                (int'(depth_q) >= DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (reject) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    stk_push  = (state == WRITE);
    stk_pop   = (state == FETCH_B) ||
                ((state == FETCH_A) && (op_q inside {OP_POP, OP_NOT, OP_ADD, OP_SUB, OP_AND}));
    stk_tos   = (state == FETCH_A) && (op_q inside {OP_TOS, OP_DUP});
    res_valid = (state == WRITE) || ((state == EXEC) && (op_q inside {OP_POP, OP_TOS}));
    res_now   = (state == EXEC) ? stk_rdata : w_q;
    res_data  = res_valid ? res_now : res_q;
    stk_wdata = stk_push ? w_q : '0;
    // Binary ops hold the first-popped word in a_q; unary ops use the live read.
    alu_a     = is_binary(op_q) ? a_q : stk_rdata;
  end

  stack_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (op_q),
    .a      (alu_a),
    .b      (stk_rdata),
    .result (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_PUSHI;
      a_q     <= '0;
      w_q     <= '0;
      res_q   <= '0;
      depth_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !reject) begin
            op_q <= op_e'(op_code);
            if (op_e'(op_code) == OP_PUSHI) begin
              w_q   <= op_imm;
              state <= WRITE;
            end else begin
              state <= FETCH_A;
            end
          end
        end
        FETCH_A: state <= is_binary(op_q) ? FETCH_B : EXEC;
        FETCH_B: begin
          a_q   <= stk_rdata;
          state <= EXEC;
        end
        EXEC: begin
          if (op_q inside {OP_POP, OP_TOS}) begin
            state <= IDLE;
          end else begin
            w_q   <= alu_y;
            state <= WRITE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase

      if (res_valid) res_q <= res_now;

      if (stk_push)     depth_q <= depth_q + DW'(1);
      else if (stk_pop) depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer with an attached behavioural stack and a queue-based reference.
module tb_stack_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_imm;
  logic       stk_push, stk_pop, stk_tos;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       res_valid;
  logic [7:0] res_data;
  logic       err;
  logic [5:0] depth;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_imm    (op_imm),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_tos   (stk_tos),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .depth     (depth)
  );

  always #5 clk = ~clk;

  // Attached stack: registered read data, follows the strobes only.
  logic [7:0] mem [0:63];
  logic [5:0] sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (stk_push) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 6'd1;
    end else if (stk_pop) begin
      stk_rdata <= mem[sp - 6'd1];
      sp        <= sp - 6'd1;
    end else if (stk_tos) begin
      stk_rdata <= mem[sp - 6'd1];
    end
  end

  int   ref_q[$];
  int   dexp;
  bit   err_exp;
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_push"}, stk_push, 0);
    chk({tag, "_pop"}, stk_pop, 0);
    chk({tag, "_tos"}, stk_tos, 0);
    chk({tag, "_rv"}, res_valid, 0);
  endtask

  task automatic run_cmd(input int op, input logic [7:0] imm);
    int         nops, lat;
    bit         rej, okdata, full;
    logic [7:0] a, b, e_val;
    int         e_push [1:4];
    int         e_pop  [1:4];
    int         e_tos  [1:4];
    int         e_rv   [1:4];
    for (int i = 1; i <= 4; i++) begin
      e_push[i] = 0; e_pop[i] = 0; e_tos[i] = 0; e_rv[i] = 0;
    end
    nops   = (op == 0) ? 0 : ((op >= 3 && op <= 5) ? 2 : 1);
    full   = ((op == 0) || (op == 7)) && (ref_q.size() >= DEPTH);
    rej    = 1'b0;
`ifdef STACK_SEQUENCER_GUARD_EN
    rej    = (ref_q.size() < nops) || full;
`endif
    okdata = (ref_q.size() >= nops);
    a      = (ref_q.size() > 0) ? 8'(ref_q[ref_q.size()-1]) : 8'd0;
    b      = (ref_q.size() > 1) ? 8'(ref_q[ref_q.size()-2]) : 8'd0;
    e_val  = 8'd0;
    lat    = 1;

    if (!rej) begin
      case (op)
        0: begin lat = 1; e_push[1] = 1; e_rv[1] = 1; e_val = imm;
                 ref_q.push_back(int'(imm)); dexp++; end
        1: begin lat = 2; e_pop[1] = 1; e_rv[2] = 1; e_val = a;
                 if (ref_q.size() > 0) void'(ref_q.pop_back()); dexp--; end
        2: begin lat = 2; e_tos[1] = 1; e_rv[2] = 1; e_val = a; end
        6: begin lat = 3; e_pop[1] = 1; e_push[3] = 1; e_rv[3] = 1; e_val = ~a;
                 if (ref_q.size() > 0) void'(ref_q.pop_back());
                 ref_q.push_back(int'(e_val)); end
        7: begin lat = 3; e_tos[1] = 1; e_push[3] = 1; e_rv[3] = 1; e_val = a;
                 ref_q.push_back(int'(e_val)); dexp++; end
        default: begin
          lat = 4; e_pop[1] = 1; e_pop[2] = 1; e_push[4] = 1; e_rv[4] = 1;
          e_val = (op == 3) ? 8'(b + a) : ((op == 4) ? 8'(b - a) : (b & a));
          repeat (2) if (ref_q.size() > 0) void'(ref_q.pop_back());
          ref_q.push_back(int'(e_val)); dexp--;
        end
      endcase
      dexp = dexp & 63;
    end

    @(negedge clk);
    chk("ready_idle", op_ready, 1);
    op_valid = 1'b1;
    op_code  = op[2:0];
    op_imm   = imm;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 3'($urandom);
    op_imm   = 8'($urandom);

    if (rej) begin
      err_exp = 1'b1;
      @(negedge clk);
      chk_quiet("reject");
      chk("reject_err", err, 1);
      chk("reject_depth", depth, dexp);
      chk("reject_ready", op_ready, 1);
      return;
    end

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("push", stk_push, e_push[c]);
      chk("pop", stk_pop, e_pop[c]);
      chk("tos", stk_tos, e_tos[c]);
      chk("res_valid", res_valid, e_rv[c]);
      chk("busy_ready", op_ready, 0);
      if (e_push[c] != 0 && okdata) chk("wdata", stk_wdata, e_val);
      if (e_rv[c] != 0 && okdata)   chk("res_data", res_data, e_val);
    end
    @(negedge clk);
    chk_quiet("done");
    chk("done_ready", op_ready, 1);
    chk("depth", depth, dexp);
    chk("err", err, err_exp);
    if (okdata) chk("res_hold", res_data, e_val);
  endtask

  task automatic reset_quiet_check;
    chk_quiet("rst");
    chk("rst_wdata", stk_wdata, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_depth", depth, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #2;
    reset_quiet_check();
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
    dexp    = 0;
    err_exp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst      = 1'b1;
    op_valid = 1'b0;
    op_code  = '0;
    op_imm   = '0;
    dexp     = 0;
    err_exp  = 1'b0;
    #2;
    reset_quiet_check();
    chk("rst_ready", op_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 5 - 3 style: b - a with b pushed first
    run_cmd(0, 8'd5);
    run_cmd(0, 8'd3);
    run_cmd(4, 8'd0);
    run_cmd(1, 8'd0);

    // 200 + 100 wraps to 44
    run_cmd(0, 8'd200);
    run_cmd(0, 8'd100);
    run_cmd(3, 8'd0);
    run_cmd(1, 8'd0);

    // POP on empty stack; err stays set across a later good command
    run_cmd(1, 8'd0);
    run_cmd(0, 8'd11);
    do_reset();

    // fill to capacity, then overflow attempts
    for (int i = 0; i < DEPTH; i++) run_cmd(0, 8'(i + 1));
    run_cmd(0, 8'd9);
    run_cmd(7, 8'd0);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 7));
`ifndef STACK_SEQUENCER_GUARD_EN
      if (ref_q.size() < ((op == 0) ? 0 : ((op >= 3 && op <= 5) ? 2 : 1)))
        op = 0;
      else if (((op == 0) || (op == 7)) && ref_q.size() >= DEPTH)
        op = 1;
`endif
      run_cmd(op, 8'($urandom));
    end

    // op_valid held high across back-to-back PUSHI 7, TOS
    do_reset();
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    op_imm   = 8'd7;
    @(posedge clk);
    #1;
    op_code  = 3'd2;
    op_imm   = 8'($urandom);
    @(negedge clk);
    chk("hold_push", stk_push, 1);
    chk("hold_wdata", stk_wdata, 8'd7);
    chk("hold_busy1", op_ready, 0);
    @(negedge clk);
    chk("hold_idle", op_ready, 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("tos_c1_ready", op_ready, 0);
    chk("tos_c1_tos", stk_tos, 1);
    @(negedge clk);
    chk("tos_c2_ready", op_ready, 0);
    chk("tos_c2_rv", res_valid, 1);
    chk("tos_c2_data", res_data, 8'd7);
    @(negedge clk);
    chk("tos_done_ready", op_ready, 1);
    chk("tos_done_data", res_data, 8'd7);
    chk("tos_done_depth", depth, 1);
    ref_q.push_back(7);
    dexp = 1;

    // reset in FETCH_B of ADD abandons the command
    run_cmd(0, 8'd1);
    run_cmd(0, 8'd2);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd3;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("add_c1_pop", stk_pop, 1);
    @(negedge clk);
    chk("add_c2_pop", stk_pop, 1);
    #1;
    rst = 1'b1;
    #1;
    reset_quiet_check();
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
    dexp    = 0;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", op_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk_quiet("post_rst");
      chk("post_rst_depth", depth, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
